ram2_responder: RTL
===================

Name: ram2_responder

Overview:
- Target-side model of the RAM2 asynchronous-SRAM pin protocol: the chip end of the bus that the CPU's RAM2 controller drives.
- Used in system simulation and in the loopback test build in place of the physical chip.
- Samples EN/OE/WE/address on clk, commits writes on the WE/EN deassertion edge, and drives read data after a programmable latency.
- Flags protocol violations through sticky error bits and counters.

Parameters:
- ADDR_W, 18: width of Ram2Addr.
- DATA_W, 16: width of Ram2Data.
- DEPTH_W, 10: backing array holds 2^DEPTH_W words, indexed by Ram2Addr[DEPTH_W-1:0]; upper bits alias.
- READ_LAT, 1: clk cycles from a sampled read request to the data drive; legal range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- Ram2Addr  in  ADDR_W  address pins
- Ram2Data  inout  DATA_W  data pins; driven only during a read, otherwise 'z'
- Ram2EN  in  1  chip enable, active-low
- Ram2OE  in  1  output enable, active-low
- Ram2WE  in  1  write enable, active-low
- busy  out  1  high while the initialise sweep runs (RAM2_RESP_INIT_EN only; otherwise tied 0)
- proto_err  out  2  sticky; bit0 = OE and WE both low, bit1 = address changed while WE low
- wr_count  out  16  committed-write counter, wraps at 16'hFFFF->0
- status_out  out  8  current FSM state encoding

Behaviour:
- Reset (rst low, async):
  - FSM to IDLE; drive_en=0 (Ram2Data='z'); proto_err=0; wr_count=0; busy=0 (or 1, see Optional Feature); sample registers cleared to EN/OE/WE=1.
  - Array contents unaffected.
- Sampling: one register stage s_en/s_oe/s_we/s_addr/s_data, loaded every clk. All decisions use sampled values.
- States (8-bit codes): IDLE 8'h00, SEL 8'h01, RD_WAIT 8'h11, RD_DRIVE 8'h12, WR_ARM 8'h21, WR_COMMIT 8'h22, INIT 8'h40.
- IDLE:
  - s_en=0 -> SEL.
  - Otherwise stay.
- SEL:
  - s_en=1 -> IDLE.
  - s_oe=0 & s_we=1 -> RD_WAIT and load lat_cnt=READ_LAT (READ_LAT=0 goes straight to RD_DRIVE).
  - s_we=0 & s_oe=1 -> WR_ARM and latch wr_addr=s_addr.
  - s_oe=0 & s_we=0 -> set proto_err[0]; stay SEL; no drive, no write.
- RD_WAIT:
  - Decrement lat_cnt; at 0 -> RD_DRIVE.
  - s_oe=1 or s_en=1 -> abort to SEL or IDLE respectively.
- RD_DRIVE:
  - Array read (synchronous) of s_addr; drive_en=1.
  - Ram2Data = mem[s_addr] while drive_en & ~Ram2OE & ~Ram2EN. The raw pin gating is combinational so the bus releases in the same cycle OE rises, with no contention with the controller's next write.
  - s_addr change while reading -> re-read the new address next cycle; not an error.
  - s_oe=1 -> SEL, drive_en=0; s_en=1 -> IDLE, drive_en=0.
- WR_ARM:
  - Each cycle capture wr_data=s_data.
  - s_addr != wr_addr -> set proto_err[1] and re-latch wr_addr.
  - s_we=1 or s_en=1 -> WR_COMMIT.
  - s_oe=0 while s_we=0 -> set proto_err[0]; the write is still committed.
- WR_COMMIT:
  - Single cycle: mem[wr_addr]<=wr_data (data from the last cycle WE was low); wr_count+1.
  - Then -> SEL if s_en=0, else IDLE.
- Latencies:
  - Read data valid on pins READ_LAT+2 clk edges after the pins present EN=OE=0: one edge for sampling, one for array/drive.
  - Write visible to a following read 1 cycle after WR_COMMIT.
- Simultaneous EN and WE rise: one commit only.
- Reset mid-write: the write is dropped. Reset mid-read: the bus releases immediately.

Optional Feature:
- Macro RAM2_RESP_INIT_EN.
- Defined:
  - After reset release, FSM enters INIT with busy=1.
  - A DEPTH_W-bit sweep counter writes 16'h0000 to every word, one per cycle, 2^DEPTH_W cycles.
  - Pin activity is ignored and the bus stays 'z'.
  - On the last word: busy=0 -> IDLE.
  - Reset during INIT restarts the sweep at 0.
- Undefined: INIT state and sweep counter absent; busy tied 0; FSM leaves reset in IDLE.

Decomposition:
- Package ram2_resp_pkg: state code localparams, default ADDR_W/DATA_W/DEPTH_W, proto_err bit indices.
- One sub-module ram2_resp_array: single-port synchronous RAM, 2^DEPTH_W x DATA_W, write-enable, synchronous read, no reset.
- Tri-state gating and FSM stay in ram2_responder.

Test Plan:
- Write/read: EN=0, WE=0 for 2 cycles at addr 18'h00010 data 16'h1234, then WE=1 -> wr_count=1. Then OE=0 at same addr -> Ram2Data=16'h1234 after READ_LAT+2 edges; OE=1 -> 'z' same cycle.
- Aliasing: write 16'hBEEF to 18'h00400 (DEPTH_W=10) -> read 18'h00000 returns 16'hBEEF.
- Contention: EN=OE=WE=0 -> proto_err=2'b01, Ram2Data stays 'z', wr_count unchanged, array unchanged.
- Address slip: WE=0 while addr changes 18'h5->18'h6, data 16'hA5A5 -> proto_err[1]=1, write lands at 18'h6.
- Reset mid-read: assert rst while in RD_DRIVE -> Ram2Data='z' within the same delta, status_out=8'h00, proto_err=0.
- With RAM2_RESP_INIT_EN: busy high for exactly 1024 cycles after reset; read of any address afterwards returns 16'h0000; a pin write during busy has no effect.

Source files
------------

// File: rtl/ram2_resp_pkg.sv
// RAM2 responder shared definitions: default widths, state codes,
// proto_err bit positions.
package ram2_resp_pkg;

  localparam int ADDR_W_DEF  = 18;
  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_W_DEF = 10;

  localparam logic [7:0] ST_IDLE      = 8'h00;
  localparam logic [7:0] ST_SEL       = 8'h01;
  localparam logic [7:0] ST_RD_WAIT   = 8'h11;
  localparam logic [7:0] ST_RD_DRIVE  = 8'h12;
  localparam logic [7:0] ST_WR_ARM    = 8'h21;
  localparam logic [7:0] ST_WR_COMMIT = 8'h22;
  localparam logic [7:0] ST_INIT      = 8'h40;

  typedef enum logic [7:0] {
    S_IDLE      = ST_IDLE,
    S_SEL       = ST_SEL,
    S_RD_WAIT   = ST_RD_WAIT,
    S_RD_DRIVE  = ST_RD_DRIVE,
    S_WR_ARM    = ST_WR_ARM,
    S_WR_COMMIT = ST_WR_COMMIT,
    S_INIT      = ST_INIT
  } state_t;

  localparam int ERR_CONT = 0;
  localparam int ERR_SLIP = 1;

endpackage

// File: rtl/ram2_responder_if.sv
// RAM2 control/address pins (EN/OE/WE active-low, Ram2Addr).
// master = CPU-side controller, slave = chip-side responder.
interface ram2_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] Ram2Addr;
  logic              Ram2EN;
  logic              Ram2OE;
  logic              Ram2WE;

  modport master (
    output Ram2Addr, Ram2EN, Ram2OE, Ram2WE
  );

  modport slave (
    input Ram2Addr, Ram2EN, Ram2OE, Ram2WE
  );
endinterface

// File: rtl/ram2_resp_array.sv
// Single-port synchronous RAM, 2^DEPTH_W x DATA_W, no reset.
// Ports: clk, we (write), re (read), addr, wdata, rdata (registered).
module ram2_resp_array #(
  parameter int DEPTH_W = 10,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram2_responder.sv
// Chip-side RAM2 async-SRAM responder: samples pins, commits writes,
// drives read data after READ_LAT, flags protocol errors.
// Ports: clk, rst (async, low), bus (addr/EN/OE/WE), Ram2Data (inout),
// busy, proto_err[1:0] (sticky), wr_count[15:0], status_out[7:0].
// Optional: RAM2_RESP_INIT_EN zero-fills the array after reset (busy=1).
module ram2_responder
  import ram2_resp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram2_responder_if.slave   bus,
  inout  wire [DATA_W-1:0]  Ram2Data,
  output logic              busy,
  output logic [1:0]        proto_err,
  output logic [15:0]       wr_count,
  output logic [7:0]        status_out
);

  localparam logic [1:0] LAT = 2'(READ_LAT);

  logic              s_en, s_oe, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  state_t            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [1:0]        err_set;
  logic              commit;
  logic              rd_en;
  logic              drive_en;

  logic               mem_we;
  logic [DEPTH_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  rdata;

`ifdef RAM2_RESP_INIT_EN
  logic [DEPTH_W-1:0] sweep_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_en   <= 1'b1;
      s_oe   <= 1'b1;
      s_we   <= 1'b1;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      s_en   <= bus.Ram2EN;
      s_oe   <= bus.Ram2OE;
      s_we   <= bus.Ram2WE;
      s_addr <= bus.Ram2Addr;
      s_data <= Ram2Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef RAM2_RESP_INIT_EN
      state_q <= S_INIT;
`else
      state_q <= S_IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    err_set = '0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!s_en) state_d = S_SEL;
      end
      S_SEL: begin
        if (s_en) begin
          state_d = S_IDLE;
        end else if (!s_oe && s_we) begin
          lat_d   = LAT;
          state_d = (LAT == 2'd0) ? S_RD_DRIVE
                                  : S_RD_WAIT;
        end else if (!s_we && s_oe) begin
          state_d = S_WR_ARM;
          wa_d    = s_addr;
          wd_d    = s_data;
        end else if (!s_we && !s_oe) begin
          err_set[ERR_CONT] = 1'b1;
        end
      end
      S_RD_WAIT: begin
        lat_d = lat_q - 2'd1;
        if (s_en) begin
          state_d = S_IDLE;
        end else if (s_oe) begin
          state_d = S_SEL;
        end else if (lat_q <= 2'd1) begin
          state_d = S_RD_DRIVE;
        end
      end
      S_RD_DRIVE: begin
        if (s_en) begin
          state_d = S_IDLE;
        end else if (s_oe) begin
          state_d = S_SEL;
        end
      end
      S_WR_ARM: begin
        if (s_we || s_en) begin
          state_d = S_WR_COMMIT;
        end else begin
          wd_d = s_data;
          if (s_addr != wa_q) begin
            err_set[ERR_SLIP] = 1'b1;
            wa_d = s_addr;
          end
          if (!s_oe) err_set[ERR_CONT] = 1'b1;
        end
      end
      S_WR_COMMIT: begin
        commit  = 1'b1;
        state_d = s_en ? S_IDLE : S_SEL;
      end
`ifdef RAM2_RESP_INIT_EN
      S_INIT: begin
        if (&sweep_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q     <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      proto_err <= '0;
      wr_count  <= '0;
    end else begin
      lat_q     <= lat_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      proto_err <= proto_err | err_set;
      if (commit) wr_count <= wr_count + 16'd1;
    end
  end

`ifdef RAM2_RESP_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_q <= '0;
    end else if (state_q == S_INIT) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end
`endif

  // Array reads on entry to and every cycle in RD_DRIVE, so the data
  // register is loaded on the same edge that turns the drive on.
  assign rd_en = (state_d == S_RD_DRIVE);

  always_comb begin
    mem_we    = commit;
    mem_addr  = commit ? wa_q[DEPTH_W-1:0]
                       : s_addr[DEPTH_W-1:0];
    mem_wdata = wd_q;
`ifdef RAM2_RESP_INIT_EN
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = '0;
    end
`endif
  end

  ram2_resp_array #(
    .DEPTH_W (DEPTH_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (rd_en),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  assign drive_en = (state_q == S_RD_DRIVE);

  // Raw pins gate the drive so the bus frees the moment OE/EN rise;
  // rst is included so a reset releases it without waiting on state.
  assign Ram2Data = (drive_en && rst && !bus.Ram2OE && !bus.Ram2EN)
                  ? rdata : 'z;

`ifdef RAM2_RESP_INIT_EN
  assign busy = (state_q == S_INIT);
`else
  assign busy = 1'b0;
`endif

  assign status_out = state_q;

endmodule
